alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, handshaked successor to the single-cycle ALU. Accepts one operation per
//   transaction on a valid/ready port and returns a registered result plus a 5-bit flags word.
//   Adds an iterative shift-add multiply and a persistent carry register for multi-word ADC/SBC
//   chains. Sits between the register file/bus and the flags register.
// PARAMETERS
//   WIDTH    8  operand/result width in bits (>=4)
//   MUL_EN   1  1: MUL opcode implemented; 0: MUL decodes as reserved
// PORTS
//   clk         in   1      system clock, all state on rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   in_valid    in   1      operation request valid
//   in_ready    out  1      block can accept a request this cycle
//   lhs_in      in   WIDTH  left operand
//   rhs_in      in   WIDTH  right operand
//   operation   in   4      opcode, see BEHAVIOUR
//   out_valid   out  1      result/flags valid
//   out_ready   in   1      consumer accepts result
//   result      out  WIDTH  low result word
//   result_hi   out  WIDTH  high word of MUL, 0 for other ops
//   flags       out  5      {lcarry, acarry, zero, sign, overflow}, registered
//   carry_q     out  1      stored carry used by ADC/SBC
//   busy        out  1      MUL iteration in progress
// BEHAVIOUR
//   Reset: in_ready=1, out_valid=0, result=0, result_hi=0, flags=0, carry_q=0, busy=0, FSM=IDLE.
//   Accept = in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
//   Opcodes (a=lhs, b=rhs, c=carry_q):
//     0 ADD a+b   1 ADC a+b+c   2 SUB a+~b+1   3 SBC a+~b+c   4 AND   5 OR   6 XOR   7 NOT a
//     8 SHL a<<1  9 SHR a>>1   10 ASR (msb kept)  11 MUL a*b unsigned  12 CMP = SUB, result := a
//     13-15 reserved: result := a, flags and carry_q unchanged.
//   Arithmetic done in WIDTH+1 bits; acarry = bit WIDTH; SUB/SBC/CMP carry=1 means no borrow.
//   overflow = (opA[msb]^r[msb]) & (opB'[msb]^r[msb]), opB' = b or ~b as added; 0 for non-arith.
//   lcarry = bit shifted out for SHL/SHR/ASR, else 0. zero = ~|result; sign = result[WIDTH-1].
//   MUL flags: zero over full 2*WIDTH product, sign = result_hi[msb], others 0.
//   carry_q <= acarry on completion of ADD/ADC/SUB/SBC/CMP; <= lcarry on SHL/SHR/ASR; else held.
//   FSM IDLE -> (accept, op!=MUL) -> result/flags registered, out_valid=1 next cycle, stay IDLE.
//   FSM IDLE -> (accept, MUL) -> BUSY, operands latched, cnt=0; each cycle one shift-add step.
//   BUSY: after WIDTH steps -> IDLE with out_valid=1; latency WIDTH+1 cycles from accept.
//   Single-cycle ops: latency 1, throughput 1/cycle while out_ready=1.
//   out_valid & ~out_ready: result/flags/carry_q held stable; in_ready=0 (no overwrite).
//   out_valid & out_ready & accept same cycle: new result replaces old, out_valid stays 1.
//   Inputs ignored when in_ready=0; changes to lhs_in/rhs_in during BUSY have no effect.
//   rst_n low mid-MUL: FSM->IDLE, partial product discarded, all outputs to reset values.
//   Adder counter and MUL counter wrap-free: cnt width clog2(WIDTH+1); no multi-issue overlap.
// TESTING (WIDTH=8)
//   ADD 0xFF+0x01 -> result 0x00, flags acarry=1 zero=1, carry_q=1, out_valid 1 cycle later.
//   SUB 0x80-0x01 -> 0x7F, acarry=1 (no borrow), overflow=1, sign=0.
//   ADD 0x34+0xF0 then ADC 0x12+0x00 -> 0x24 (c=1), then 0x13; 16-bit chain 0x1234+0x00F0.
//   MUL 0x0F*0x11 -> result 0xFF, result_hi 0x00, busy 8 cycles, out_valid at cycle 9.
//   Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result held, no loss.
//   rst_n pulse during MUL step 4 -> out_valid=0, flags=0, next ADD 1+1 returns 0x02.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU with an iterative shift-add multiplier and a persistent carry for ADC/SBC chains.
// Single-cycle ops complete on the accept edge; MUL occupies the block for WIDTH cycles.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] lhs_in,
    input  logic [WIDTH-1:0] rhs_in,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags,
    output logic             carry_q,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ASR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {S_IDLE, S_BUSY} state_e;

    state_e                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       result_hi_q, result_hi_d;
    logic [4:0]             flags_q, flags_d;
    logic                   carry_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;

    logic [WIDTH-1:0]       add_b;
    logic                   add_cin;
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       alu_res;
    logic [WIDTH-1:0]       flag_val;
    logic                   alu_lcarry;
    logic                   alu_ovf;
    logic [4:0]             alu_flags;
    logic                   is_arith, is_shift, is_logic, is_mul, is_reserved;
    logic [2*WIDTH-1:0]     prod_next;
    logic                   accept;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == S_BUSY);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

    // Single-cycle datapath: one shared adder serves ADD/ADC/SUB/SBC/CMP.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        is_arith    = operation inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP};
        is_shift    = operation inside {OP_SHL, OP_SHR, OP_ASR};
        is_logic    = operation inside {OP_AND, OP_OR, OP_XOR, OP_NOT};
        is_mul      = (operation == OP_MUL) && (MUL_EN != 0);
        is_reserved = !(is_arith || is_shift || is_logic || is_mul);

        add_b = (operation inside {OP_SUB, OP_SBC, OP_CMP}) ? ~rhs_in : rhs_in;
        case (operation)
            OP_ADC, OP_SBC: add_cin = carry_q;
            OP_SUB, OP_CMP: add_cin = 1'b1;
            default:        add_cin = 1'b0;
        endcase
        sum = {1'b0, lhs_in} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

        alu_res    = lhs_in;
        alu_lcarry = 1'b0;
        case (operation)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: alu_res = sum[WIDTH-1:0];
            OP_AND: alu_res = lhs_in & rhs_in;
            OP_OR:  alu_res = lhs_in | rhs_in;
            OP_XOR: alu_res = lhs_in ^ rhs_in;
            OP_NOT: alu_res = ~lhs_in;
            OP_SHL: begin
                alu_res    = {lhs_in[WIDTH-2:0], 1'b0};
                alu_lcarry = lhs_in[WIDTH-1];
            end
            OP_SHR: begin
                alu_res    = {1'b0, lhs_in[WIDTH-1:1]};
                alu_lcarry = lhs_in[0];
            end
            OP_ASR: begin
                alu_res    = {lhs_in[WIDTH-1], lhs_in[WIDTH-1:1]};
                alu_lcarry = lhs_in[0];
            end
            default: alu_res = lhs_in;
        endcase

        // CMP returns a unchanged but reports the flags of the subtraction.
        flag_val  = is_arith ? sum[WIDTH-1:0] : alu_res;
        alu_ovf   = is_arith && (lhs_in[WIDTH-1] ^ sum[WIDTH-1])
                             && (add_b[WIDTH-1] ^ sum[WIDTH-1]);
        alu_flags = {alu_lcarry, is_arith && sum[WIDTH], ~|flag_val,
                     flag_val[WIDTH-1], alu_ovf};
    end

    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d  = S_BUSY;
                    mcand_d  = {{WIDTH{1'b0}}, lhs_in};
                    mplier_d = rhs_in;
                    prod_d   = '0;
                    cnt_d    = '0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = alu_res;
                    result_hi_d = '0;
                    if (!is_reserved) begin
                        flags_d = alu_flags;
                    end
                    if (is_arith) begin
                        carry_d = alu_flags[3];
                    end else if (is_shift) begin
                        carry_d = alu_lcarry;
                    end
                end
            end
            S_BUSY: begin
                prod_d   = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = prod_next[WIDTH-1:0];
                    result_hi_d = prod_next[2*WIDTH-1:WIDTH];
                    flags_d     = {2'b00, ~|prod_next, prod_next[2*WIDTH-1], 1'b0};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values computed above.
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed ops push expected results,
// a monitor pops and compares on every output handshake.
module tb_alu_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic [4:0]   flg;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] lhs_in = '0;
    logic [W-1:0] rhs_in = '0;
    logic [3:0]   operation = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [4:0]   flags;
    logic         carry_q;
    logic         busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pop    = 0;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lhs_in    (lhs_in),
        .rhs_in    (rhs_in),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .carry_q   (carry_q),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request and hold it until an edge where in_ready was high.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic push, input logic [W-1:0] e_res, input logic [W-1:0] e_hi,
                         input logic [4:0] e_flg, input logic e_c);
        int waited = 0;
        exp_t e;
        e.res = e_res; e.hi = e_hi; e.flg = e_flg; e.c = e_c;
        operation = op;
        lhs_in    = a;
        rhs_in    = b;
        in_valid  = 1'b1;
        if (push) exp_q.push_back(e);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: out_ready and outputs are stable from negedge to the transfer edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("result[%0d]", n_pop), result, e.res);
                    check($sformatf("result_hi[%0d]", n_pop), result_hi, e.hi);
                    check($sformatf("flags[%0d]", n_pop), flags, e.flg);
                    check($sformatf("carry_q[%0d]", n_pop), carry_q, e.c);
                    n_pop++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_result", result, 0);
        check("rst_result_hi", result_hi, 0);
        check("rst_flags", flags, 0);
        check("rst_carry", carry_q, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // flags = {lcarry, acarry, zero, sign, overflow}
        issue(4'd0, 8'hFF, 8'h01, 1, 8'h00, 8'h00, 5'h0C, 1);
        check("add_latency_out_valid", out_valid, 1);
        issue(4'd2,  8'h80, 8'h01, 1, 8'h7F, 8'h00, 5'h09, 1);
        issue(4'd0,  8'h34, 8'hF0, 1, 8'h24, 8'h00, 5'h08, 1);
        issue(4'd1,  8'h12, 8'h00, 1, 8'h13, 8'h00, 5'h00, 0);
        issue(4'd8,  8'h81, 8'h00, 1, 8'h02, 8'h00, 5'h10, 1);
        issue(4'd4,  8'hF0, 8'h0F, 1, 8'h00, 8'h00, 5'h04, 1);
        issue(4'd5,  8'h80, 8'h01, 1, 8'h81, 8'h00, 5'h02, 1);
        issue(4'd6,  8'hAA, 8'hAA, 1, 8'h00, 8'h00, 5'h04, 1);
        issue(4'd7,  8'h0F, 8'h00, 1, 8'hF0, 8'h00, 5'h02, 1);
        issue(4'd9,  8'h81, 8'h00, 1, 8'h40, 8'h00, 5'h10, 1);
        issue(4'd10, 8'h81, 8'h00, 1, 8'hC0, 8'h00, 5'h12, 1);
        issue(4'd10, 8'h02, 8'h00, 1, 8'h01, 8'h00, 5'h00, 0);
        issue(4'd3,  8'h10, 8'h01, 1, 8'h0E, 8'h00, 5'h08, 1);
        issue(4'd12, 8'h05, 8'h03, 1, 8'h05, 8'h00, 5'h08, 1);
        issue(4'd13, 8'h5A, 8'h11, 1, 8'h5A, 8'h00, 5'h08, 1);
        drain();

        // MUL: busy for 8 cycles, operand changes while busy must not matter.
        issue(4'd11, 8'h0F, 8'h11, 1, 8'hFF, 8'h00, 5'h00, 1);
        n = 0;
        while (busy && n < 50) begin
            lhs_in = 8'($urandom);
            rhs_in = 8'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        check("mul_busy_cycles", n, 8);
        check("mul_out_valid_after_busy", out_valid, 1);
        issue(4'd11, 8'hFF, 8'hFF, 1, 8'h01, 8'hFE, 5'h02, 1);
        drain();

        // Backpressure: result held and no second accept while out_ready=0.
        out_ready = 1'b0;
        issue(4'd0, 8'h01, 8'h02, 1, 8'h03, 8'h00, 5'h00, 0);
        fork
            issue(4'd0, 8'h04, 8'h05, 1, 8'h09, 8'h00, 5'h00, 0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("bp_in_ready[%0d]", i), in_ready, 0);
                    check($sformatf("bp_result_held[%0d]", i), result, 8'h03);
                    check($sformatf("bp_out_valid[%0d]", i), out_valid, 1);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset pulse during MUL step 4 discards the partial product.
        issue(4'd11, 8'h0F, 8'h11, 0, 8'h00, 8'h00, 5'h00, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_flags", flags, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_carry", carry_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(4'd0, 8'h01, 8'h01, 1, 8'h02, 8'h00, 5'h00, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
